// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift, rotate, invert and clear, with a
// shift counter that pulses word_valid once per WIDTH counted serial shifts.
module univ_shift_reg #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                       clk,
  input  logic                       clear_n,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_l,
  input  logic                       sin_r,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qbar,
  output logic                       sout_l,
  output logic                       sout_r,
  output logic [$clog2(WIDTH)-1:0]   cnt,
  output logic                       word_valid
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_SHL    = 3'b010,
    MODE_SHR    = 3'b011,
    MODE_ROTL   = 3'b100,
    MODE_ROTR   = 3'b101,
    MODE_INVERT = 3'b110,
    MODE_SCLR   = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic             word_valid_next;
  logic             count_shift;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    q_next          = q;
    cnt_next        = cnt;
    word_valid_next = 1'b0;
    count_shift     = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        MODE_HOLD:   q_next = q;
        MODE_LOAD: begin
          q_next   = d;
          cnt_next = '0;
        end
        MODE_SHL: begin
          q_next      = {q[WIDTH-2:0], sin_r};
          count_shift = 1'b1;
        end
        MODE_SHR: begin
          q_next      = {sin_l, q[WIDTH-1:1]};
          count_shift = 1'b1;
        end
        MODE_ROTL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROTR:   q_next = {q[0], q[WIDTH-1:1]};
        MODE_INVERT: q_next = ~q;
        MODE_SCLR: begin
          q_next   = '0;
          cnt_next = '0;
        end
        default:     q_next = q;
      endcase
    end

    // Both shift directions feed the same word; the WIDTH-th shift closes it.
    if (count_shift) begin
      if (cnt == CW'(WIDTH - 1)) begin
        cnt_next        = '0;
        word_valid_next = 1'b1;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!clear_n) begin
      q          <= RESET_VAL[WIDTH-1:0];
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      q          <= q_next;
      cnt        <= cnt_next;
      word_valid <= word_valid_next;
    end
  end

  assign qbar   = ~q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5): directed
// scenarios followed by randomized traffic against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROTL = 3'd4, ROTR = 3'd5, INV = 3'd6, SCLR = 3'd7;

  logic             clk = 1'b0;
  logic             clear_n, en, sin_l, sin_r;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q, qbar;
  logic             sout_l, sout_r, word_valid;
  logic [2:0]       cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: value as an integer 0..255, shifts since last word.
  int m_q   = 0;
  int m_cnt = 0;
  int m_wv  = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(32'hA5)) dut (
    .clk(clk), .clear_n(clear_n), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .qbar(qbar), .sout_l(sout_l),
    .sout_r(sout_r), .cnt(cnt), .word_valid(word_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic e, input logic [2:0] m, input int dv,
                              input int sl, input int sr, input logic cl);
    if (!cl) begin
      m_q = 'hA5; m_cnt = 0; m_wv = 0;
    end else if (!e) begin
      m_wv = 0;
    end else begin
      m_wv = 0;
      case (m)
        LOAD: begin m_q = dv; m_cnt = 0; end
        SHL:  m_q = (m_q * 2 + sr) % 256;
        SHR:  m_q = m_q / 2 + sl * 128;
        ROTL: m_q = (m_q * 2) % 256 + m_q / 128;
        ROTR: m_q = m_q / 2 + (m_q % 2) * 128;
        INV:  m_q = 255 - m_q;
        SCLR: begin m_q = 0; m_cnt = 0; end
        default: ;
      endcase
      if (m == SHL || m == SHR) begin
        m_cnt = (m_cnt + 1) % WIDTH;
        m_wv  = (m_cnt == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},      32'(q),          32'(m_q));
    check({tag, ".qbar"},   32'(qbar),       32'(255 - m_q));
    check({tag, ".sout_l"}, 32'(sout_l),     32'(m_q / 128));
    check({tag, ".sout_r"}, 32'(sout_r),     32'(m_q % 2));
    check({tag, ".cnt"},    32'(cnt),        32'(m_cnt));
    check({tag, ".wv"},     32'(word_valid), 32'(m_wv));
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  // Unused data inputs are driven X so any leak shows up on the outputs.
  task automatic step(input string tag, input logic e, input logic [2:0] m,
                      input logic [7:0] dv, input logic sl, input logic sr,
                      input logic cl);
    clear_n = cl; en = e; mode = m;
    d     = (m == LOAD) ? dv : 'x;
    sin_l = (m == SHR)  ? sl : 1'bx;
    sin_r = (m == SHL)  ? sr : 1'bx;
    @(posedge clk);
    model_update(e, m, int'(dv), int'(sl), int'(sr), cl);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'b0100_1101;
    clear_n = 1'b0; en = 1'b1; mode = LOAD; d = 8'hFF; sin_l = 1'b0; sin_r = 1'b0;

    // Reset has priority over a pending load.
    step("rst0", 1, LOAD, 8'hFF, 0, 0, 0);
    step("rst1", 1, LOAD, 8'hFF, 0, 0, 0);
    check("rst.q", 32'(q), 32'hA5);
    check("rst.qbar", 32'(qbar), 32'h5A);
    check("rst.cnt", 32'(cnt), 0);
    check("rst.wv", 32'(word_valid), 0);
    step("rel_load", 1, LOAD, 8'hFF, 0, 0, 1);
    check("rel_load.q", 32'(q), 32'hFF);

    // Load then shift in both directions.
    step("ld81", 1, LOAD, 8'h81, 0, 0, 1);
    step("shl1", 1, SHL, 8'h00, 0, 0, 1);
    check("shl1.q", 32'(q), 32'h02);
    check("shl1.sout_l", 32'(sout_l), 0);
    step("shr1", 1, SHR, 8'h00, 1, 0, 1);
    check("shr1.q", 32'(q), 32'h81);
    check("shr1.cnt", 32'(cnt), 2);

    // Serial word via eight right shifts (LSB-first pattern 1,0,1,1,0,0,1,0).
    step("sclr", 1, SCLR, 8'h00, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step("word1", 1, SHR, 8'h00, pat[i], 0, 1);
      check("word1.wv", 32'(word_valid), (i == 7) ? 1 : 0);
    end
    check("word1.q", 32'(q), 32'h4D);
    check("word1.cnt", 32'(cnt), 0);
    for (int i = 0; i < 8; i++) begin
      step("word2", 1, (i % 2 == 0) ? SHL : SHR, 8'h00, 1, 0, 1);
      check("word2.wv", 32'(word_valid), (i == 7) ? 1 : 0);
    end

    // Rotate and invert leave the counter alone.
    step("ld81b", 1, LOAD, 8'h81, 0, 0, 1);
    step("rotl", 1, ROTL, 8'h00, 0, 0, 1);
    check("rotl.q", 32'(q), 32'h03);
    step("rotr", 1, ROTR, 8'h00, 0, 0, 1);
    check("rotr.q", 32'(q), 32'h81);
    step("inv", 1, INV, 8'h00, 0, 0, 1);
    check("inv.q", 32'(q), 32'h7E);
    check("inv.qbar", 32'(qbar), 32'h81);
    check("inv.cnt", 32'(cnt), 0);

    // Enable gating.
    step("ld3c", 1, LOAD, 8'h3C, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("en0", 0, SHL, 8'h00, 0, 1, 1);
    check("en0.q", 32'(q), 32'h3C);
    check("en0.cnt", 32'(cnt), 0);

    // Mid-word reset discards the partial word.
    for (int i = 0; i < 5; i++) step("pre_rst", 1, SHL, 8'h00, 0, 1, 1);
    check("pre_rst.cnt", 32'(cnt), 5);
    step("mid_rst", 1, SHL, 8'h00, 0, 1, 0);
    check("mid_rst.q", 32'(q), 32'hA5);
    check("mid_rst.cnt", 32'(cnt), 0);
    for (int i = 0; i < 8; i++) begin
      step("post_rst", 1, SHL, 8'h00, 0, 1, 1);
      check("post_rst.wv", 32'(word_valid), (i == 7) ? 1 : 0);
    end

    // Randomized traffic, biased toward shifts so words complete often.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] rm;
      logic       rcl, ren;
      rcl = ($urandom % 40) != 0;
      ren = ($urandom % 8) != 0;
      rm  = ($urandom % 3 != 0) ? (SHL + 3'($urandom % 2)) : 3'($urandom % 8);
      step("rand", ren, rm, 8'($urandom), 1'($urandom), 1'($urandom), rcl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
